// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one LSB-first serial shift path between N_REQ requesters.
// A granted word is captured at the grant edge, shifted out under frame, then acknowledged with done.
module serial_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   serial_out,
    output logic                   frame,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0]   shift_reg, shift_nxt;
    logic [IDX_W-1:0]   owner_nxt;
    logic [N_REQ-1:0]   grant_nxt, done_nxt;
    logic               serial_nxt, frame_nxt;

    logic [2*N_REQ-1:0] rot;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic [WIDTH-1:0]   win_word;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit is the round-robin winner.
    always_comb begin
        rot      = {req, req} >> ptr;
        found    = 1'b0;
        win_sum  = '0;
        win      = '0;
        win_word = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                win_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            end
        end
        if (win_sum >= (IDX_W + 1)'(N_REQ)) begin
            win_sum = win_sum - (IDX_W + 1)'(N_REQ);
        end
        win = win_sum[IDX_W-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_word = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        owner_nxt   = owner;
        grant_nxt   = '0;
        done_nxt    = '0;
        serial_nxt  = 1'b0;
        frame_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    shift_nxt   = win_word;
                    owner_nxt   = win;
                    bit_cnt_nxt = '0;
                    ptr_nxt     = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                serial_nxt  = shift_reg[0];
                shift_nxt   = shift_reg >> 1;
                frame_nxt   = 1'b1;
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            serial_out <= 1'b0;
            frame      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            owner      <= owner_nxt;
            grant      <= grant_nxt;
            done       <= done_nxt;
            serial_out <= serial_nxt;
            frame      <= frame_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed grant order and serialized words.
module tb_serial_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       grant;
    logic                   serial_out;
    logic                   frame;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [IDX_W-1:0]       owner;

    serial_tx_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .serial_out (serial_out),
        .frame      (frame),
        .done       (done),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: a transfer is a count of edges since its grant.
    bit               m_valid = 1'b0;
    bit               m_active;
    bit               m_got;
    int               m_k, m_w, m_owner, m_ptr;
    logic [WIDTH-1:0] m_word;
    logic [N_REQ-1:0] e_grant, e_done;
    logic             e_serial, e_frame;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
            e_grant  = '0;
            e_done   = '0;
            e_serial = 1'b0;
            e_frame  = 1'b0;
        end else if (m_valid) begin
            e_grant  = '0;
            e_done   = '0;
            e_serial = 1'b0;
            e_frame  = 1'b0;
            if (!m_active) begin
                m_got = 1'b0;
                m_w   = 0;
                for (int k = 0; k < N_REQ; k++) begin
                    if (!m_got && req[(m_ptr + k) % N_REQ]) begin
                        m_got = 1'b1;
                        m_w   = (m_ptr + k) % N_REQ;
                    end
                end
                if (m_got) begin
                    m_word   = data_in[m_w*WIDTH +: WIDTH];
                    m_owner  = m_w;
                    m_ptr    = (m_w + 1) % N_REQ;
                    m_active = 1'b1;
                    m_k      = 0;
                    e_grant  = N_REQ'(1) << m_w;
                end
            end else begin
                m_k++;
                if (m_k <= WIDTH) begin
                    e_serial = m_word[m_k-1];
                    e_frame  = 1'b1;
                end else begin
                    e_done   = N_REQ'(1) << m_owner;
                    m_active = 1'b0;
                end
            end
        end
    end

    // Observation log for the directed scenarios.
    int               obs_g[$];
    int               obs_gc[$];
    logic [WIDTH-1:0] obs_w[$];
    logic [N_REQ-1:0] obs_d[$];
    logic [WIDTH-1:0] acc;
    int               bpos;
    int               busy_cnt;

    always @(negedge clk) begin
        if (m_valid) begin
            check("grant",      32'(grant),      32'(e_grant));
            check("done",       32'(done),       32'(e_done));
            check("serial_out", 32'(serial_out), 32'(e_serial));
            check("frame",      32'(frame),      32'(e_frame));
            check("busy",       32'(busy),       32'(m_active));
            check("owner",      32'(owner),      32'(m_owner));
        end
        if (grant != '0) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) obs_g.push_back(i);
            end
            obs_gc.push_back(cyc);
            acc  = '0;
            bpos = 0;
        end
        if (frame && bpos < WIDTH) begin
            acc[bpos] = serial_out;
            bpos++;
        end
        if (done != '0) begin
            obs_w.push_back(acc);
            obs_d.push_back(done);
        end
        if (busy) busy_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int ng, nw, nd;
    logic [WIDTH-1:0] exp_words [5];

    initial begin
        rst     = 1'b1;
        req     = '0;
        data_in = '0;
        tick(2);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_frame", 32'(frame), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        rst = 1'b0;
        tick(1);

        // Single request from requester 2, word 1011.
        data_in  = {4'h8, 4'hB, 4'h2, 4'h1};
        req      = 4'b0100;
        busy_cnt = 0;
        tick(1);
        check("t1_grant_pulse", 32'(grant), 32'h4);
        req = '0;
        tick(6);
        check("t1_owner",   32'(owner),        32'd2);
        check("t1_winner",  32'(obs_g[$]),     32'd2);
        check("t1_bits",    32'(obs_w[$]),     32'hB);
        check("t1_done",    32'(obs_d[$]),     32'h4);
        check("t1_busy_len", 32'(busy_cnt),    32'd5);

        // ptr is 3, so with 0 and 3 requesting, 3 wins.
        req = 4'b1001;
        tick(1);
        req = '0;
        tick(6);
        check("ptr3_winner", 32'(obs_g[$]), 32'd3);
        check("ptr3_word",   32'(obs_w[$]), 32'h8);

        // Wrap and skip: ptr is 0, req 0110 -> 1 then 2.
        ng  = obs_g.size();
        req = 4'b0110;
        tick(7);
        req = '0;
        tick(6);
        check("wrap_count",  32'(obs_g.size() - ng),          32'd2);
        check("wrap_first",  32'(obs_g[ng]),                  32'd1);
        check("wrap_second", 32'(obs_g[ng+1]),                32'd2);
        check("wrap_gap",    32'(obs_gc[ng+1] - obs_gc[ng]),  32'd6);

        // Late request from 0, withdrawn request from 2 during requester 1's transfer.
        ng  = obs_g.size();
        nd  = obs_d.size();
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(1);
        req = 4'b0101;
        tick(2);
        req = 4'b0001;
        tick(3);
        req = '0;
        tick(6);
        check("late_count",  32'(obs_g.size() - ng),         32'd2);
        check("late_first",  32'(obs_g[ng]),                 32'd1);
        check("late_second", 32'(obs_g[ng+1]),               32'd0);
        check("late_gap",    32'(obs_gc[ng+1] - obs_gc[ng]), 32'd6);
        check("late_done0",  32'(obs_d[nd]),                 32'h2);
        check("late_done1",  32'(obs_d[nd+1]),               32'h1);

        // Word changed after capture must not affect the transfer.
        data_in[3:0] = 4'b0011;
        req          = 4'b0001;
        tick(1);
        data_in[3:0] = 4'b1100;
        req          = '0;
        tick(6);
        check("capture_winner", 32'(obs_g[$]), 32'd0);
        check("capture_bits",   32'(obs_w[$]), 32'h3);

        // Reset after the second bit aborts the frame.
        nd  = obs_d.size();
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_frame",  32'(frame),      32'h0);
        check("abort_busy",   32'(busy),       32'h0);
        check("abort_serial", 32'(serial_out), 32'h0);
        check("abort_done",   32'(done),       32'h0);
        tick(2);
        check("abort_no_done", 32'(obs_d.size()), 32'(nd));

        // Full contention after reset: 0,1,2,3,0 at 6-cycle spacing.
        data_in      = {4'h8, 4'h4, 4'h2, 4'h1};
        exp_words[0] = 4'h1;
        exp_words[1] = 4'h2;
        exp_words[2] = 4'h4;
        exp_words[3] = 4'h8;
        exp_words[4] = 4'h1;
        ng  = obs_g.size();
        nw  = obs_w.size();
        req = 4'b1111;
        tick(25);
        req = '0;
        tick(6);
        check("rr_count", 32'(obs_g.size() - ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant%0d", i), 32'(obs_g[ng+i]), 32'(i % N_REQ));
            check($sformatf("rr_word%0d", i),  32'(obs_w[nw+i]), 32'(exp_words[i]));
            if (i > 0) begin
                check($sformatf("rr_gap%0d", i), 32'(obs_gc[ng+i] - obs_gc[ng+i-1]), 32'd6);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parallel-to-serial shift path between N_REQ requesters.
- Each requester presents a WIDTH-bit word with a request line.
- The block grants one requester at a time, captures its word, and shifts it out LSB-first with a frame strobe.
- When the word is fully sent, it pulses a per-requester done.
- Sits between the local producers and the single serial output pin.

Parameters:
- N_REQ, 4: number of requesters; minimum 2.
- WIDTH, 4: bits per word; minimum 2.
- IDX_W, $clog2(N_REQ): width of the owner index; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_REQ  request per requester; level, held until granted.
- data_in  input  N_REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot, single-cycle pulse; the word is captured at that edge.
- serial_out  output  1  serial data, LSB first.
- frame  output  1  high while serial_out carries a valid bit.
- done  output  N_REQ  one-hot, single-cycle pulse after the last bit of the owner's word.
- busy  output  1  high while a transfer is in progress (state SHIFT or DONE).
- owner  output  IDX_W  index of the current or most recent winner.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, ptr=0, bit_cnt=0, shift_reg=0, owner=0.
  - grant=0, done=0, serial_out=0, frame=0, busy=0.
  - Overrides every other input in the same cycle.
  - Reset mid-transfer aborts the frame: no done pulse, the word is discarded, and the pointer returns to 0.
- State IDLE:
  - At edge E0 with req!=0, select winner w = first set req bit searching from ptr upward, wrapping N_REQ-1 -> 0.
  - At E0: grant<=onehot(w), shift_reg<=word w, owner<=w, bit_cnt<=0, ptr<=(w+1) mod N_REQ, state<=SHIFT.
  - With req==0: outputs hold their idle values.
- State SHIFT:
  - At each edge E1..E_WIDTH: serial_out<=shift_reg[bit_cnt], frame<=1, bit_cnt<=bit_cnt+1, grant<=0.
  - At E_WIDTH (bit_cnt==WIDTH-1): state<=DONE.
- State DONE:
  - At E_WIDTH+1: done<=onehot(owner), frame<=0, serial_out<=0, state<=IDLE.
  - done clears at the next edge.
- Timing:
  - Grant latency is 1 edge from a sampled request in IDLE.
  - The first bit is visible after E1 and the last bit after E_WIDTH.
  - Minimum period between grants is WIDTH+2 cycles: the earliest next grant is at E_WIDTH+2.
- Requester rules:
  - Hold req and data_in stable until the grant pulse is seen.
  - data_in changes after the capture edge have no effect on the transfer in flight.
  - req dropped before a grant: no transfer, no pulses.
  - req still high after its grant: treated as a new request and arbitrated fairly from the updated ptr, so the same requester can win again only after every other asserted requester has been served.
  - req changes during SHIFT/DONE: ignored until the block returns to IDLE.
- Simultaneous events: done for one transfer and the grant for the next never occur in the same cycle; there is always a one-cycle IDLE gap.
- Widths: bit_cnt is $clog2(WIDTH)+1 bits, so there is no wrap at WIDTH a power of 2. ptr wrap is an explicit modulo.
- Outputs are all registered, except busy, which is decoded from state.

Test Plan:
1. Single request, with WIDTH=4, N_REQ=4:
   - Stimulus: req=4'b0100, word2=4'b1011 held, request asserted before E0.
   - Response: grant=4'b0100 for 1 cycle; serial_out=1,1,0,1 on 4 consecutive cycles with frame=1; then done=4'b0100 for 1 cycle; owner=2; busy high 5 cycles; ptr becomes 3.
2. Full contention:
   - Stimulus: req=4'b1111 held constantly, words 0x1,0x2,0x4,0x8.
   - Response: grants in order 0,1,2,3,0 at exactly 6-cycle spacing; each frame carries the matching word LSB-first.
3. Pointer wrap and skip:
   - Stimulus: after a grant to requester 3 (ptr=0), assert req=4'b0110.
   - Response: requester 1 is granted next, then requester 2; requester 0 is never granted.
4. Late and withdrawn requests:
   - Stimulus: requester 0 raises req during requester 1's SHIFT; requester 2 raises req then drops it before the block returns to IDLE.
   - Response: requester 0 is granted at the first IDLE edge; requester 2 gets no grant and no done.
5. Reset mid-frame:
   - Stimulus: assert rst for 1 cycle after the second bit of a transfer.
   - Response: next cycle frame=0, busy=0, serial_out=0, no done; the next request with req=4'b1111 is granted to requester 0.
6. Data change after capture:
   - Stimulus: word0=4'b0011 at the grant edge, changed to 4'b1100 on the following cycle.
   - Response: serialized bits are 1,1,0,0.
